counter_sweep_ctrl: RTL and testbench



---
 rtl/counter_sweep_pkg.sv | 23 ++
 rtl/counter_sweep_ctrl_watchdog.sv | 30 +++
 rtl/counter_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_pkg.sv
// Shared types and constants for the counter sweep controller.
package counter_sweep_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  typedef enum logic {
    REPEAT   = 1'b0,
    PINGPONG = 1'b1
  } mode_e;

  localparam int DEFAULT_TIMEOUT = 300;

endpackage

// File: rtl/counter_sweep_ctrl_watchdog.sv
// sweep_watchdog: counts RUN cycles since the last endpoint and flags a stalled counter.
// Instantiated by counter_sweep_ctrl only when CTRL_WATCHDOG_EN is defined.
module sweep_watchdog
  import counter_sweep_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cyc_cnt;

  // Fires on the TIMEOUT-th consecutive RUN cycle without an endpoint.
  assign expire = run & ~clear & (cyc_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !run || clear) begin
      cyc_cnt <= '0;
    end else if (!expire) begin
      cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sweep controller driving a programmable up/down counter between start_value and limit.
// Optional stall watchdog enabled with the CTRL_WATCHDOG_EN macro.
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [WIDTH-1:0]   start_value,
  input  logic [WIDTH-1:0]   limit,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic [WIDTH-1:0]   count,
  input  logic               tc,
  input  logic               zero,
  output logic               load,
  output logic               enable,
  output logic               up_down,
  output logic [WIDTH-1:0]   load_value,
  output logic [WIDTH-1:0]   max_count,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  logic [1:0]         state;
  logic               dir;
  mode_e              mode_q;
  logic [SWEEP_W-1:0] sweeps_q;
  logic [SWEEP_W-1:0] sweep_nxt;
  logic               in_run;
  logic               endpoint;
  logic               last_sweep;
  logic               bad_cmd;
  logic               wd_expire;
  logic               unused_ok;

  assign in_run     = (state == ST_RUN);
  assign endpoint   = in_run & ((dir & tc) | (~dir & zero));
  assign sweep_nxt  = sweep_cnt + SWEEP_W'(1);
  assign last_sweep = (sweeps_q != '0) && (sweep_nxt == sweeps_q);
  assign bad_cmd    = (state == ST_IDLE) & start & (start_value > limit);

`ifdef CTRL_WATCHDOG_EN
  sweep_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .run    (in_run),
    .clear  (endpoint),
    .expire (wd_expire)
  );
  assign unused_ok = ^count;
`else
  assign wd_expire = 1'b0;
  assign unused_ok = ^{count, 32'(TIMEOUT)};
`endif

  // Abort and watchdog expiry freeze the counter in the very cycle they are seen.
  assign busy    = (state != ST_IDLE);
  assign enable  = in_run & ~abort & ~wd_expire & ~endpoint;
  assign load    = ~abort & ((state == ST_LOAD) |
                             (endpoint & ~last_sweep & (mode_q == REPEAT)));
  assign up_down = busy & dir;
  assign done    = (state == ST_DONE) & ~abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dir        <= 1'b0;
      mode_q     <= REPEAT;
      sweeps_q   <= '0;
      load_value <= '0;
      max_count  <= '0;
      sweep_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bad_cmd) begin
            err <= 1'b1;
          end else if (start) begin
            load_value <= start_value;
            max_count  <= limit;
            mode_q     <= mode_e'(mode);
            sweeps_q   <= sweeps;
            sweep_cnt  <= '0;
            dir        <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= abort ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (wd_expire) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else if (endpoint) begin
            sweep_cnt <= sweep_nxt;
            if (last_sweep) begin
              state <= ST_DONE;
            end else if (mode_q == PINGPONG) begin
              dir <= ~dir;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl paired with a behavioural up/down counter;
// expected timing comes from closed-form sweep lengths.
module tb_counter_sweep_ctrl;
  import counter_sweep_pkg::*;

  localparam int WIDTH   = 8;
  localparam int SWEEP_W = 8;
`ifdef CTRL_WATCHDOG_EN
  localparam int TIMEOUT = 20;
`else
  localparam int TIMEOUT = DEFAULT_TIMEOUT;
`endif

  logic clk = 1'b0;
  logic rst, start, abort, mode;
  logic [WIDTH-1:0]   start_value, limit, load_value, max_count;
  logic [WIDTH-1:0]   count = '0;
  logic [SWEEP_W-1:0] sweeps, sweep_cnt;
  logic tc, zero, load, enable, up_down, busy, done, err;
  logic flags_stuck = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  counter_sweep_ctrl #(
    .WIDTH   (WIDTH),
    .SWEEP_W (SWEEP_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .start_value (start_value),
    .limit       (limit),
    .sweeps      (sweeps),
    .count       (count),
    .tc          (tc),
    .zero        (zero),
    .load        (load),
    .enable      (enable),
    .up_down     (up_down),
    .load_value  (load_value),
    .max_count   (max_count),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sweep_cnt   (sweep_cnt)
  );

  // Stand-in for prog_counter: load wins over enable, wraps at max_count and 0.
  always @(posedge clk) begin
    if (load) count <= load_value;
    else if (enable) begin
      if (up_down) count <= (count == max_count) ? '0 : count + WIDTH'(1);
      else         count <= (count == '0) ? max_count : count - WIDTH'(1);
    end
  end
  assign tc   = ~flags_stuck & (count == max_count);
  assign zero = ~flags_stuck & (count == '0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Index 0 is the cycle start is presented; done is expected at index exp_done.
  task automatic run_sweep(input logic m, input int s, input int l, input int n);
    int exp_done, exp_cnt, k, got, cnt_at, sc_at;
    logic ud_bad, range_bad;
    if (m) begin
      exp_done = 1 + (l - s + 1) + (n - 1) * (l + 1) + 1;
      exp_cnt  = (n % 2 == 1) ? l : 0;
    end else begin
      exp_done = 1 + n * (l - s + 1) + 1;
      exp_cnt  = l;
    end
    @(negedge clk);
    mode = m; start_value = WIDTH'(s); limit = WIDTH'(l); sweeps = SWEEP_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_after_start", load, 1'b1);
    check("enable_in_load", enable, 1'b0);
    k = 1; got = -1; cnt_at = -1; sc_at = -1; ud_bad = 1'b0; range_bad = 1'b0;
    while (got < 0 && k < exp_done + 4) begin
      @(negedge clk);
      k++;
      if (!m && busy && !up_down) ud_bad = 1'b1;
      if (int'(count) > l) range_bad = 1'b1;
      if (done) begin got = k; cnt_at = int'(count); sc_at = int'(sweep_cnt); end
      start = (k == 3);
      if (k == 3) begin start_value = '0; limit = '1; end
    end
    start = 1'b0;
    check("done_cycle", got, exp_done);
    check("count_at_done", cnt_at, exp_cnt);
    check("sweep_cnt_at_done", sc_at, n);
    check("load_value_kept", load_value, s);
    check("max_count_kept", max_count, l);
    check("up_down_in_repeat", ud_bad, 1'b0);
    check("count_in_range", range_bad, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k, exp_sc, l, s, n;
    logic seen_done, m;
    logic [WIDTH-1:0] frozen;

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    start_value = '0; limit = '0; sweeps = '0;
    repeat (3) @(negedge clk);
    check("rst_load", load, 1'b0);
    check("rst_enable", enable, 1'b0);
    check("rst_up_down", up_down, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_load_value", load_value, 0);
    check("rst_max_count", max_count, 0);
    check("rst_sweep_cnt", sweep_cnt, 0);
    rst = 1'b0;

    run_sweep(1'b1, 5, 10, 3);
    run_sweep(1'b0, 2, 4, 2);
    run_sweep(1'b1, 4, 4, 2);
    run_sweep(1'b1, 0, 0, 3);
    run_sweep(1'b0, 0, 0, 2);
    run_sweep(1'b0, 7, 7, 1);

    // Bad command: start_value above limit.
    @(negedge clk);
    mode = 1'b1; start_value = 8'd9; limit = 8'd4; sweeps = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad_cmd_err", err, 1'b1);
    check("bad_cmd_busy", busy, 1'b0);
    check("bad_cmd_load", load, 1'b0);
    @(negedge clk);
    check("bad_cmd_err_pulse", err, 1'b0);
    check("bad_cmd_stays_idle", busy, 1'b0);

    // Unbounded ping-pong 0..3, abort after 40 cycles; every sweep is 4 cycles long.
    @(negedge clk);
    mode = 1'b1; start_value = 8'd0; limit = 8'd3; sweeps = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    exp_sc = (41 - 2) / 4;
    check("sweeps_before_abort", sweep_cnt, exp_sc);
    check("count_before_abort", count, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_enable", enable, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_no_done", done, 1'b0);
    check("abort_beats_endpoint", sweep_cnt, exp_sc);
    frozen = count;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_count_frozen", count, frozen);
    check("no_done_unbounded", seen_done, 1'b0);

    // Reset in the middle of a run.
    @(negedge clk);
    mode = 1'b0; start_value = 8'd0; limit = 8'd15; sweeps = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (count != 8'd7 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("reached_count_7", count, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_enable", enable, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sweep_cnt", sweep_cnt, 0);
    check("midrst_load_value", load_value, 0);
    frozen = count;
    @(negedge clk);
    check("midrst_count_frozen", count, frozen);
    run_sweep(1'b1, 5, 10, 3);

`ifdef CTRL_WATCHDOG_EN
    // Counter flags stuck low: watchdog must end the run.
    flags_stuck = 1'b1;
    @(negedge clk);
    mode = 1'b1; start_value = 8'd0; limit = 8'd5; sweeps = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; n = -1;
    while (n < 0 && k < 80) begin
      @(negedge clk);
      k++;
      if (err) n = k;
    end
    check("watchdog_err_cycle", n, TIMEOUT + 2);
    check("watchdog_idle", busy, 1'b0);
    flags_stuck = 1'b0;
`endif

    for (int i = 0; i < 8; i++) begin
      l = int'($urandom_range(12, 0));
      s = int'($urandom_range(l, 0));
      n = int'($urandom_range(4, 1));
      m = 1'($urandom_range(1, 0));
      run_sweep(m, s, l, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
